dff_variants: RTL and testbench

Bank of three D flip-flop flavours sharing one data input and one clock: plain (no reset), resettable, and set/resettable. It provides the basic storage primitives for the surrounding sequential logic and lets all three be verified against a single common stimulus. Each flavour is a separate submodule so it can be instantiated on its own: `DF1`, `DFR1` and `DFSR1`. The top `dff_variants` instantiates one of each, all of width `WIDTH`.

---
 rtl/dff_variants.sv | 131 +++++++++++++
 tb/tb_dff_variants.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dff_variants.sv
// -----------------------------------------------------------------------------
// dff_variants
//   Bank of three D flip-flop flavours that share one data input and one clock.
//   Each flavour is a standalone submodule so it can be reused on its own:
//     DF1   - plain DFF, no reset
//     DFR1  - DFF with asynchronous active-low reset
//     DFSR1 - DFF with asynchronous active-low reset and set (reset wins)
//
// Ports (top):
//   clk : rising-edge clock shared by all flops
//   rst : asynchronous active-low reset, clears q2 and q3
//   st  : asynchronous active-low set, forces q3 to all-ones
//   d   : WIDTH-bit data input shared by all flops
//   q1  : DF1 output
//   q2  : DFR1 output
//   q3  : DFSR1 output
// -----------------------------------------------------------------------------

// Plain DFF: d captured on every rising edge, no reset value.
module DF1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture data on every rising edge.
    always_ff @(posedge clk) begin
        q <= d;
    end

endmodule

// DFF with asynchronous active-low reset to zero.
module DFR1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Asynchronous clear, otherwise capture on the rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= {WIDTH{1'b0}};
        end else begin
            q <= d;
        end
    end

endmodule

// DFF with asynchronous active-low set and reset; reset has priority.
module DFSR1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             st,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Storage element: reset beats set, set beats capture.
    always_ff @(posedge clk or negedge rst or negedge st) begin
        if (!rst) begin
            q_r <= {WIDTH{1'b0}};
        end else if (!st) begin
            q_r <= {WIDTH{1'b1}};
        end else begin
            q_r <= d;
        end
    end

    // Level-sensitive override of the stored value. An edge-triggered block
    // alone cannot react when rst rises while st is still low (set must win
    // at once, not at the next clock), so the active force is applied here.
    // Only rst/st and the register feed this mux; d never reaches q directly.
    always_comb begin
        q = q_r;
        if (!rst) begin
            q = {WIDTH{1'b0}};
        end else if (!st) begin
            q = {WIDTH{1'b1}};
        end else begin
            q = q_r;
        end
    end

endmodule

// Top: one of each flavour on the shared clock and data.
module dff_variants #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             st,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3
);

    DF1 #(.WIDTH(WIDTH)) u_df1 (
        .clk (clk),
        .d   (d),
        .q   (q1)
    );

    DFR1 #(.WIDTH(WIDTH)) u_dfr1 (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (q2)
    );

    DFSR1 #(.WIDTH(WIDTH)) u_dfsr1 (
        .clk (clk),
        .st  (st),
        .rst (rst),
        .d   (d),
        .q   (q3)
    );

endmodule

// File: tb/tb_dff_variants.sv
// -----------------------------------------------------------------------------
// tb_dff_variants
//   Directed stimulus against a 1-bit and an 8-bit dff_variants instance.
//   Each check pushes the hand-computed expected outputs into a queue and
//   fires an event; a separate monitor pops the entry and compares it with
//   the outputs the DUT is presenting at that moment.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dff_variants;

    typedef struct {
        string      name;
        bit         w8;      // 1: compare the WIDTH=8 instance
        bit         c1;      // compare q1
        bit         c2;      // compare q2
        bit         c3;      // compare q3
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] e3;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       st;
    logic [0:0] d;
    logic [0:0] q1;
    logic [0:0] q2;
    logic [0:0] q3;

    logic       rst8;
    logic       st8;
    logic [7:0] d8;
    logic [7:0] q1_8;
    logic [7:0] q2_8;
    logic [7:0] q3_8;

    exp_t sb[$];
    event chk_ev;
    int   checks;
    int   failures;
    bit   done;

    dff_variants #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .st  (st),
        .d   (d),
        .q1  (q1),
        .q2  (q2),
        .q3  (q3)
    );

    dff_variants #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst8),
        .st  (st8),
        .d   (d8),
        .q1  (q1_8),
        .q2  (q2_8),
        .q3  (q3_8)
    );

    // 20 ns clock, rising edges at 10, 30, 50, ...
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Queue an expectation for the 1-bit instance.
    task automatic exp1(input string name, input bit c1, input logic e1,
                        input bit c2, input logic e2, input bit c3, input logic e3);
        exp_t e;
        e.name = name; e.w8 = 1'b0;
        e.c1 = c1; e.c2 = c2; e.c3 = c3;
        e.e1 = {7'd0, e1}; e.e2 = {7'd0, e2}; e.e3 = {7'd0, e3};
        sb.push_back(e);
        ->chk_ev;
        #0.1;
    endtask

    // Queue an expectation for the 8-bit instance.
    task automatic exp8(input string name, input bit c1, input logic [7:0] e1,
                        input bit c2, input logic [7:0] e2, input bit c3, input logic [7:0] e3);
        exp_t e;
        e.name = name; e.w8 = 1'b1;
        e.c1 = c1; e.c2 = c2; e.c3 = c3;
        e.e1 = e1; e.e2 = e2; e.e3 = e3;
        sb.push_back(e);
        ->chk_ev;
        #0.1;
    endtask

    task automatic cmp(input string name, input string sig,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%h expected=%h at %0t", name, sig, act, exp, $time);
        end
    endtask

    // Monitor: drain the scoreboard whenever an expectation is posted.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.w8) begin
                    if (e.c1) cmp(e.name, "q1", q1_8, e.e1);
                    if (e.c2) cmp(e.name, "q2", q2_8, e.e2);
                    if (e.c3) cmp(e.name, "q3", q3_8, e.e3);
                end else begin
                    if (e.c1) cmp(e.name, "q1", {7'd0, q1}, e.e1);
                    if (e.c2) cmp(e.name, "q2", {7'd0, q2}, e.e2);
                    if (e.c3) cmp(e.name, "q3", {7'd0, q3}, e.e3);
                end
            end
        end
    end

    // Watchdog: the run must end on its own.
    initial begin
        #5000;
        if (!done) begin
            $display("FAIL watchdog actual=running expected=finished");
            $fatal(1, "timeout");
        end
    end

    // Directed stimulus.
    initial begin
        checks = 0; failures = 0; done = 1'b0;
        rst = 1'b0; st = 1'b1; d = 1'b1;
        rst8 = 1'b0; st8 = 1'b1; d8 = 8'h00;

        // Power-up reset
        #5;   exp1("por_t5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;                                   // t=11
        exp1("por_edge10", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk); rst = 1'b1; #1;                       // t=21
        exp1("rst_release_hold", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;                                   // t=31
        exp1("first_capture", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Data tracking; d change mid-cycle must not reach outputs
        @(negedge clk); d = 1'b0; #1;                         // t=41
        exp1("no_comb_path", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;                                   // t=51
        exp1("track_0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Async set mid-cycle
        #3.9; st = 1'b0; #1;                                  // st falls ~t=55
        exp1("async_set", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk); st = 1'b1; d = 1'b1; #1;              // t=61
        exp1("set_release_hold", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;                                   // t=71
        exp1("track_1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Async reset mid-cycle, held across two edges
        #3.9; rst = 1'b0; #1;                                 // rst falls ~t=75
        exp1("async_rst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        exp1("rst_hold_e1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        exp1("rst_hold_e2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Set released while reset still low: q3 stays 0
        @(negedge clk); st = 1'b0; #1;
        exp1("collide", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        st = 1'b1; #1;
        exp1("st_rel_under_rst", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Collision, then reset released first: set takes over at once
        st = 1'b0; d = 1'b0; #1;
        exp1("collide2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1; #1;
        exp1("rst_rel_set_wins", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        exp1("set_held_edge", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk); st = 1'b1; #1;
        exp1("st_rel_hold", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        exp1("follow_after_rel", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk); d = 1'b1;
        @(posedge clk); #1;
        exp1("follow_1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        // WIDTH=8 instance
        @(negedge clk); #1;
        exp8("w8_rst", 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00);
        rst8 = 1'b1; st8 = 1'b0; #1;
        exp8("w8_set", 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'hFF);
        rst8 = 1'b0; #1;
        exp8("w8_rst_over_set", 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h00);
        @(negedge clk); rst8 = 1'b1; st8 = 1'b1; d8 = 8'hA5;
        @(posedge clk); #1;
        exp8("w8_capture_a5", 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1, 8'hA5);
        @(negedge clk); d8 = 8'h3C;
        @(posedge clk); #1;
        exp8("w8_capture_3c", 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1, 8'h3C);
        @(negedge clk); st8 = 1'b0; #1;
        exp8("w8_set_bus", 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1, 8'hFF);

        #5;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
